mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between fetch and load/store.
// Optional ARB_PERF_CNT_EN adds stall/grant/override performance counters.
module mem_port_arbiter #(
    parameter int ADDR_W       = 30,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_stall_cycles,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_starve_overrides
`endif
);
    localparam logic [2:0] ML = 3'(MEM_LATENCY);
    localparam logic [3:0] SL = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     state;
    logic       own_d;
    logic       we_q;
    logic [2:0] lat_cnt;
    logic [3:0] starve_cnt;
    logic       force_f;
    logic       grant_d;

    assign if_stall = if_req && !if_rvalid;
    assign d_stall  = d_req && !d_rvalid;

    always_comb begin
        force_f = (SL != 4'd0) && if_req && d_req && (starve_cnt == SL);
        grant_d = d_req && !force_f;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            own_d      <= 1'b0;
            we_q       <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            mem_en     <= 1'b0;
            mem_wren   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            mem_en    <= 1'b0;
            mem_wren  <= 1'b0;
            case (state)
                IDLE: if (if_req || d_req) begin
                    own_d      <= grant_d;
                    we_q       <= grant_d && d_we;
                    mem_en     <= 1'b1;
                    mem_wren   <= grant_d && d_we;
                    mem_addr   <= grant_d ? d_addr : if_addr;
                    mem_wdata  <= d_wdata;
                    starve_cnt <= (grant_d && if_req) ? ((starve_cnt == SL) ? starve_cnt : starve_cnt + 4'd1) : 4'd0;
                    state      <= ISSUE;
                end
                ISSUE: begin
                    lat_cnt <= ML;
                    state   <= WAIT;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    // capture lands MEM_LATENCY cycles after the mem_en cycle
                    if (lat_cnt == 3'd1) begin
                        if (!own_d) if_rdata <= mem_rdata;
                        else if (!we_q) d_rdata <= mem_rdata;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if_rvalid <= !own_d;
                    d_rvalid  <= own_d;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_if_stall_cycles  <= '0;
            perf_d_grants         <= '0;
            perf_starve_overrides <= '0;
        end else begin
            perf_if_stall_cycles  <= perf_if_stall_cycles + {31'b0, if_stall};
            perf_d_grants         <= perf_d_grants + {31'b0, state == IDLE && grant_d};
            perf_starve_overrides <= perf_starve_overrides + {31'b0, state == IDLE && force_f};
        end
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, starvation and reset behaviour.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [29:0] if_addr = '0, d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        if_rvalid, if_stall, d_rvalid, d_stall, mem_en, mem_wren;
    logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [29:0] mem_addr;

    logic        if_req3 = 1'b0, d_req3 = 1'b0, d_we3 = 1'b0;
    logic [29:0] if_addr3 = '0, d_addr3 = '0;
    logic [31:0] d_wdata3 = '0;
    logic        if_rvalid3, if_stall3, d_rvalid3, d_stall3, mem_en3, mem_wren3;
    logic [31:0] if_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
    logic [29:0] mem_addr3;

    mem_port_arbiter #(.ADDR_W(30), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_en(mem_en), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(30), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(2)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req3), .if_addr(if_addr3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3), .if_stall(if_stall3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_rvalid(d_rvalid3), .d_rdata(d_rdata3), .d_stall(d_stall3),
        .mem_en(mem_en3), .mem_wren(mem_wren3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    // latency-1 memory: data visible only in the single cycle after mem_en
    logic [31:0] mem [0:63];
    logic        rd_v = 1'b0;
    logic [31:0] rd_d = '0;
    always @(posedge clk) begin
        if (rst) begin
            mem[16] <= 32'h8C010004;
            mem[17] <= 32'h11111111;
            mem[33] <= 32'h21212121;
            rd_v    <= 1'b0;
        end else begin
            rd_v <= mem_en;
            if (mem_en) begin
                rd_d <= mem[mem_addr[5:0]];
                if (mem_wren) mem[mem_addr[5:0]] <= mem_wdata;
            end
        end
    end
    assign mem_rdata = rd_v ? rd_d : 32'hBAD0BAD0;

    // latency-3 memory: data visible only exactly three cycles after mem_en
    logic [2:0]  v3 = '0;
    logic [31:0] p3 [3];
    always @(posedge clk) begin
        v3    <= {v3[1:0], mem_en3};
        p3[0] <= {2'b00, mem_addr3} ^ 32'hC0DE0000;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_rdata3 = v3[2] ? p3[2] : 32'hBAD0BAD0;

    int total = 0;
    int bad = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        repeat (3) tick();
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_wren", mem_wren, 1'b0);
        chk32("rst_mem_addr", {2'b00, mem_addr}, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk1("rst_if_rvalid", if_rvalid, 1'b0);
        chk1("rst_d_rvalid", d_rvalid, 1'b0);
        chk32("rst_if_rdata", if_rdata, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        chk1("rst_if_stall", if_stall, 1'b0);
        chk1("rst3_mem_wren", mem_wren3, 1'b0);
        chk1("rst3_d_rvalid", d_rvalid3, 1'b0);
        chk1("rst3_d_stall", d_stall3, 1'b0);
        chk32("rst3_d_rdata", d_rdata3, 32'h0);
        chk32("rst3_mem_wdata", mem_wdata3, 32'h0);
        rst = 1'b0;
        tick();

        // single fetch
        if_req = 1'b1; if_addr = 30'h10;
        #1 chk1("f_stall_req", if_stall, 1'b1);
        tick();
        chk1("f_mem_en", mem_en, 1'b1);
        chk32("f_mem_addr", {2'b00, mem_addr}, 32'h10);
        chk1("f_mem_wren", mem_wren, 1'b0);
        tick();
        chk1("f_wait_en", mem_en, 1'b0);
        chk32("f_wait_addr", {2'b00, mem_addr}, 32'h10);
        tick();
        chk1("f_done_rvalid", if_rvalid, 1'b0);
        tick();
        chk1("f_rvalid", if_rvalid, 1'b1);
        chk32("f_rdata", if_rdata, 32'h8C010004);
        chk1("f_d_rvalid", d_rvalid, 1'b0);
        chk1("f_stall_end", if_stall, 1'b0);
        if_req = 1'b0;
        tick();
        chk1("f_pulse_end", if_rvalid, 1'b0);
        chk1("f_no_regrant", mem_en, 1'b0);

        // store then load
        d_req = 1'b1; d_we = 1'b1; d_addr = 30'h20; d_wdata = 32'hDEADBEEF;
        tick();
        chk1("st_mem_en", mem_en, 1'b1);
        chk1("st_mem_wren", mem_wren, 1'b1);
        chk32("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk32("st_mem_addr", {2'b00, mem_addr}, 32'h20);
        tick();
        chk1("st_wait_wren", mem_wren, 1'b0);
        repeat (2) tick();
        chk1("st_ack", d_rvalid, 1'b1);
        chk32("st_rdata_kept", d_rdata, 32'h0);
        d_we = 1'b0;
        tick();
        chk1("ld_mem_en", mem_en, 1'b1);
        chk1("ld_mem_wren", mem_wren, 1'b0);
        repeat (3) tick();
        chk1("ld_rvalid", d_rvalid, 1'b1);
        chk32("ld_rdata", d_rdata, 32'hDEADBEEF);
        d_req = 1'b0;
        tick();

        // simultaneous requests: data first, then fetch
        if_req = 1'b1; if_addr = 30'h10; d_req = 1'b1; d_addr = 30'h20;
        tick();
        chk32("sim_first_addr", {2'b00, mem_addr}, 32'h20);
        repeat (3) tick();
        chk1("sim_d_rvalid", d_rvalid, 1'b1);
        chk1("sim_if_stall", if_stall, 1'b1);
        d_req = 1'b0;
        tick();
        chk32("sim_second_addr", {2'b00, mem_addr}, 32'h10);
        chk1("sim_if_stall2", if_stall, 1'b1);
        repeat (3) tick();
        chk1("sim_if_rvalid", if_rvalid, 1'b1);
        chk32("sim_if_rdata", if_rdata, 32'h8C010004);
        chk1("sim_if_stall_end", if_stall, 1'b0);
        if_req = 1'b0;
        tick();

        // starvation limit 2: D D F D D F
        if_req = 1'b1; if_addr = 30'h11; d_req = 1'b1; d_we = 1'b0; d_addr = 30'h21;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk1("sv_mem_en", mem_en, 1'b1);
            chk32("sv_order", {2'b00, mem_addr}, (k % 3 == 2) ? 32'h11 : 32'h21);
            repeat (3) tick();
            if (k % 3 == 2) begin
                chk1("sv_if_rvalid", if_rvalid, 1'b1);
                chk32("sv_if_rdata", if_rdata, 32'h11111111);
            end else begin
                chk1("sv_d_rvalid", d_rvalid, 1'b1);
                chk32("sv_d_rdata", d_rdata, 32'h21212121);
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();

        // latency 3 instance
        if_req3 = 1'b1; if_addr3 = 30'h5;
        tick();
        chk1("l3_mem_en", mem_en3, 1'b1);
        chk32("l3_mem_addr", {2'b00, mem_addr3}, 32'h5);
        repeat (3) tick();
        chk32("l3_not_early", if_rdata3, 32'h0);
        chk32("l3_wait_addr", {2'b00, mem_addr3}, 32'h5);
        tick();
        chk1("l3_done_rvalid", if_rvalid3, 1'b0);
        chk32("l3_rdata", if_rdata3, 32'hC0DE0005);
        tick();
        chk1("l3_rvalid", if_rvalid3, 1'b1);
        chk1("l3_stall_end", if_stall3, 1'b0);
        if_req3 = 1'b0;
        tick();

        // reset during WAIT of a load
        d_req = 1'b1; d_we = 1'b0; d_addr = 30'h11;
        tick();
        chk1("rw_issue", mem_en, 1'b1);
        tick();
        #1 rst = 1'b1;
        #1;
        chk32("rw_mem_addr", {2'b00, mem_addr}, 32'h0);
        chk32("rw_d_rdata", d_rdata, 32'h0);
        chk32("rw_if_rdata", if_rdata, 32'h0);
        chk1("rw_mem_en", mem_en, 1'b0);
        d_req = 1'b0;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        chk1("rw_no_rvalid", d_rvalid, 1'b0);
        tick();
        chk1("rw_no_rvalid2", d_rvalid, 1'b0);
        if_req = 1'b1; if_addr = 30'h10;
        tick();
        chk1("rw_f_mem_en", mem_en, 1'b1);
        repeat (3) tick();
        chk1("rw_f_rvalid", if_rvalid, 1'b1);
        chk32("rw_f_rdata", if_rdata, 32'h8C010004);
        chk1("rw_f_d_rvalid", d_rvalid, 1'b0);
        if_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
